// File: rtl/booth_csa_sequencer.sv
// Sequential radix-4 Booth signed multiplier: one Booth digit per cycle into a 2N-bit carry-save pair, then one resolving add.
// Optional early termination on redundant upper multiplier bits: define BOOTH_SEQ_EARLY_TERM_EN.
module booth_csa_sequencer #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int W  = 2 * N;
    localparam int ND = N / 2;
    localparam int IW = (ND > 1) ? $clog2(ND) : 1;
    localparam logic [IW-1:0] LAST_DIGIT = IW'(ND - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_RESOLVE
    } state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [W-1:0]  r_sum;
    logic [W-1:0]  r_carry;
    logic [W-1:0]  r_product;
    logic [IW-1:0] r_i;
    logic          r_done;

    logic [N:0]    w_bExt;
    logic [IW:0]   w_twoI;
    logic [2:0]    w_triplet;
    logic [W-1:0]  w_aExt;
    logic [W-1:0]  w_ppDigit;
    logic [W-1:0]  w_pp;
    logic [W-1:0]  w_sumNext;
    logic [W-1:0]  w_carryNext;
    logic          w_lastDigit;
    logic          w_earlyDone;

    // B[-1] is the implicit zero appended below the LSB
    assign w_bExt    = {r_b, 1'b0};
    assign w_twoI    = {r_i, 1'b0};
    assign w_triplet = 3'(w_bExt >> w_twoI);
    assign w_aExt    = {{N{r_a[N-1]}}, r_a};

    always_comb begin
        w_ppDigit = '0;
        case (w_triplet)
            3'b001, 3'b010: w_ppDigit = w_aExt;
            3'b011:         w_ppDigit = w_aExt << 1;
            3'b100:         w_ppDigit = ~(w_aExt << 1) + W'(1);
            3'b101, 3'b110: w_ppDigit = ~w_aExt + W'(1);
            default:        w_ppDigit = '0;
        endcase
    end

    assign w_pp        = w_ppDigit << w_twoI;
    assign w_sumNext   = r_sum ^ r_carry ^ w_pp;
    assign w_carryNext = ((r_sum & r_carry) | (r_sum & w_pp) | (r_carry & w_pp)) << 1;
    assign w_lastDigit = (r_i == LAST_DIGIT);

`ifdef BOOTH_SEQ_EARLY_TERM_EN
    // Remaining digits are all zero once B[N-1:2i+1] is a pure sign run
    logic [N-1:0] w_bUpper;
    assign w_bUpper    = N'($signed(r_b) >>> {r_i, 1'b1});
    assign w_earlyDone = (w_bUpper == '0) || (w_bUpper == '1);
`else
    assign w_earlyDone = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:    if (start) w_nextState = S_ACCUM;
            S_ACCUM:   if (w_lastDigit || w_earlyDone) w_nextState = S_RESOLVE;
            S_RESOLVE: w_nextState = S_IDLE;
            default:   w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state == S_ACCUM) || (r_state == S_RESOLVE);
        done    = r_done;
        product = r_product;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_sum     <= '0;
            r_carry   <= '0;
            r_i       <= '0;
            r_product <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= multiplicand;
                        r_b     <= multiplier;
                        r_sum   <= '0;
                        r_carry <= '0;
                        r_i     <= '0;
                    end
                end
                S_ACCUM: begin
                    r_sum   <= w_sumNext;
                    r_carry <= w_carryNext;
                    if (!(w_lastDigit || w_earlyDone)) begin
                        r_i <= r_i + IW'(1);
                    end
                end
                S_RESOLVE: begin
                    r_product <= r_sum + r_carry;
                    r_done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_csa_sequencer.sv
// Directed self-checking bench for booth_csa_sequencer (N=32), latency expectations follow BOOTH_SEQ_EARLY_TERM_EN.
module tb_booth_csa_sequencer;

    localparam int N      = 32;
    localparam int L_FULL = 17;
`ifdef BOOTH_SEQ_EARLY_TERM_EN
    localparam int L_B5     = 3;
    localparam int L_B6     = 3;
    localparam int L_B4     = 3;
    localparam int L_B1     = 2;
    localparam int L_BM1    = 2;
    localparam int PULSE_AT = 2;
    localparam int RST_AT   = 2;
`else
    localparam int L_B5     = 17;
    localparam int L_B6     = 17;
    localparam int L_B4     = 17;
    localparam int L_B1     = 17;
    localparam int L_BM1    = 17;
    localparam int PULSE_AT = 5;
    localparam int RST_AT   = 8;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   multiplicand;
    logic [N-1:0]   multiplier;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    booth_csa_sequencer #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called #1 after an edge; returns #1 after the accepting edge with operands scrambled
    task automatic startOp(input logic [N-1:0] a, input logic [N-1:0] b);
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplicand = 32'hDEAD_BEEF;
        multiplier   = 32'h1234_5678;
    endtask

    task automatic waitDone(input int pulseAt, output int cycles);
        cycles = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k == pulseAt) begin
                start        = 1'b1;
                multiplicand = 32'd9;
                multiplier   = 32'd9;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic countDones(input int nCycles, output int nDone);
        nDone = 0;
        for (int k = 0; k < nCycles; k++) begin
            @(posedge clk);
            #1;
            if (done) nDone++;
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic [2*N-1:0] expProd, input int expLat);
        int lat;
        startOp(a, b);
        checkOutput({tag, "_busy"}, busy, 1);
        waitDone(0, lat);
        checkOutput({tag, "_lat"}, lat, expLat);
        checkOutput({tag, "_prod"}, product, expProd);
        checkOutput({tag, "_busyAtDone"}, busy, 0);
    endtask

    initial begin
        int lat;
        int nDone;

        rst          = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_prod", product, 0);
        rst = 1'b0;

        applyStimulus("t1", 32'd3, 32'd5, 64'h0000_0000_0000_000F, L_B5);
        @(posedge clk);
        #1;
        checkOutput("t1_donePulse", done, 0);
        checkOutput("t1_hold", product, 64'h0000_0000_0000_000F);

        applyStimulus("t2a", 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, L_B6);
        @(posedge clk);
        #1;
        applyStimulus("t2b", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, L_FULL);
        @(posedge clk);
        #1;

        startOp(32'd3, 32'd5);
        waitDone(PULSE_AT, lat);
        checkOutput("t3_lat", lat, L_B5);
        checkOutput("t3_prod", product, 64'h0000_0000_0000_000F);
        countDones(20, nDone);
        checkOutput("t3_noSecondDone", nDone, 0);
        checkOutput("t3_hold", product, 64'h0000_0000_0000_000F);

        startOp(32'd2, 32'd2);
        for (int k = 1; k < RST_AT; k++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("t4_inflight", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("t4_rstBusy", busy, 0);
        checkOutput("t4_rstDone", done, 0);
        checkOutput("t4_rstProd", product, 0);
        countDones(20, nDone);
        checkOutput("t4_noDone", nDone, 0);
        applyStimulus("t4b", 32'd4, 32'd4, 64'h0000_0000_0000_0010, L_B4);
        @(posedge clk);
        #1;

        applyStimulus("t5a", 32'd10, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF6, L_BM1);
        applyStimulus("t5b", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, L_BM1);
        @(posedge clk);
        #1;

        applyStimulus("t6a", 32'd123, 32'd1, 64'h0000_0000_0000_007B, L_B1);
        @(posedge clk);
        #1;
        applyStimulus("t6b", 32'd123, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FF85, L_BM1);
        @(posedge clk);
        #1;
        applyStimulus("t6c", 32'd3, 32'h4000_0000, 64'h0000_0000_C000_0000, L_FULL);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
